// File: rtl/smax_reduce_seq_pkg.sv
// Shared fixed-point reduction definitions: sequencer state encoding and
// the most-negative value helper used to neutralise unused max inputs.
package smax_reduce_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } red_state_e;

   // Two's-complement most-negative value for a given width, returned
   // sign-extended to 64 bits; callers keep the low 'width' bits.
   function automatic logic [63:0] most_neg(input int width);
      logic signed [63:0] one;
      one = 64'sd1;
      return -(one <<< (width - 1));
   endfunction

endpackage

// File: rtl/smax_reduce_seq_if.sv
// Fixed-point clock/reset bundle; WIDTH is the element width shared by
// every block hanging off this bundle.
interface fixedp #(
   parameter int WIDTH = 16
) ();
   logic clk;
   logic reset;

   modport master (output clk, output reset);
   modport slave  (input  clk, input  reset);
endinterface

// File: rtl/smax_reduce_seq_smax.sv
// Registered signed maximum of two operands; f is deliberately not reset,
// callers neutralise stale contents by driving the most-negative value.
module smax #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] f
);

   always_ff @(posedge clk) begin
      f <= (a > b) ? a : b;
   end

endmodule

// File: rtl/smax_reduce_seq.sv
// Streams a vector through one shared smax and returns the running maximum
// and the index of its first occurrence.
//
//  state   | meaning
//  IDLE    | waiting for start; in_valid ignored
//  RUN     | accepting elements, one per clock
//  DONE    | result presented until out_ready
module smax_reduce_seq
   import smax_reduce_seq_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int LEN_WIDTH = 16
) (
   fixedp.slave                        g,
   input  logic                        start,
   input  logic [LEN_WIDTH-1:0]        len,
   input  logic signed [WIDTH-1:0]     in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic signed [WIDTH-1:0]     out_data,
   output logic [LEN_WIDTH-1:0]        out_idx,
   output logic                        out_empty,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);

   localparam logic [63:0]             NEG_FULL = most_neg(WIDTH);
   localparam logic signed [WIDTH-1:0] NEG      = NEG_FULL[WIDTH-1:0];
   localparam logic [LEN_WIDTH-1:0]    ONE      = LEN_WIDTH'(1);

   red_state_e state_q, state_d;

   logic [LEN_WIDTH-1:0]    len_q;
   logic [LEN_WIDTH-1:0]    cnt_q;
   logic [LEN_WIDTH-1:0]    idx_q;
   logic                    first_q;
   logic                    empty_q;

   logic                    accept;
   logic                    last;
   logic                    launch;
   logic signed [WIDTH-1:0] smax_a;
   logic signed [WIDTH-1:0] smax_b;
   logic signed [WIDTH-1:0] smax_f;

   smax #(.WIDTH(WIDTH)) u_smax (
      .clk (g.clk),
      .a   (smax_a),
      .b   (smax_b),
      .f   (smax_f)
   );

   always_ff @(posedge g.clk) begin
      if (g.reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      launch    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               launch  = 1'b1;
               state_d = (len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            in_ready = 1'b1;
            if (in_valid && last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy   = (state_q != ST_IDLE);
   assign accept = in_valid & in_ready;
   assign last   = (cnt_q == (len_q - ONE));

   // Bubbles and DONE feed the most-negative value so f simply holds.
   assign smax_a = accept  ? in_data : NEG;
   assign smax_b = first_q ? NEG     : smax_f;

   always_ff @(posedge g.clk) begin
      if (g.reset) begin
         len_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         first_q <= 1'b0;
         empty_q <= 1'b0;
      end else if (launch) begin
         len_q   <= len;
         cnt_q   <= '0;
         idx_q   <= '0;
         first_q <= (len != '0);
         empty_q <= (len == '0);
      end else if (accept) begin
         cnt_q   <= cnt_q + ONE;
         first_q <= 1'b0;
         // Strict compare so ties keep the earlier index.
         if (first_q || (in_data > smax_f)) begin
            idx_q <= cnt_q;
         end
      end
   end

   assign out_data  = (out_valid && !empty_q) ? smax_f : '0;
   assign out_idx   = out_valid ? idx_q : '0;
   assign out_empty = out_valid & empty_q;

endmodule

// File: tb/tb_smax_reduce_seq.sv
// Directed-vector bench for smax_reduce_seq with hand-computed results.
module tb_smax_reduce_seq;

   fixedp #(.WIDTH(16)) g ();

   logic               start;
   logic [15:0]        len;
   logic signed [15:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] out_data;
   logic [15:0]        out_idx;
   logic               out_empty;
   logic               out_valid;
   logic               out_ready;
   logic               busy;

   int nvec = 0;
   int nerr = 0;

   smax_reduce_seq #(.WIDTH(16), .LEN_WIDTH(16)) dut (
      .g         (g),
      .start     (start),
      .len       (len),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_empty (out_empty),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial g.clk = 1'b0;
   always #5 g.clk = ~g.clk;

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge g.clk);
      #1;
   endtask

   task automatic begin_red(input int n);
      start = 1'b1;
      len   = 16'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input int v);
      in_valid = 1'b1;
      in_data  = 16'(v);
      tick();
      in_valid = 1'b0;
      in_data  = 16'sd0;
   endtask

   task automatic chk_result(input string tag, input int d, input int idx, input int emp);
      chk({tag, ".valid"}, int'(out_valid), 1);
      chk({tag, ".data"},  int'(out_data),  d);
      chk({tag, ".idx"},   int'(out_idx),   idx);
      chk({tag, ".empty"}, int'(out_empty), emp);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".busy_after"},  int'(busy),      0);
      chk({tag, ".valid_after"}, int'(out_valid), 0);
   endtask

   initial begin
      start     = 1'b0;
      len       = '0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      g.reset   = 1'b1;
      tick();
      tick();
      g.reset = 1'b0;

      chk("rst.in_ready",  int'(in_ready),  0);
      chk("rst.out_valid", int'(out_valid), 0);
      chk("rst.busy",      int'(busy),      0);
      chk("rst.out_data",  int'(out_data),  0);
      chk("rst.out_idx",   int'(out_idx),   0);
      chk("rst.out_empty", int'(out_empty), 0);

      // basic: 3,-7,12,5 -> 12 @2
      begin_red(4);
      chk("t1.in_ready", int'(in_ready), 1);
      chk("t1.busy",     int'(busy),     1);
      feed(3); feed(-7); feed(12);
      chk("t1.not_yet", int'(out_valid), 0);
      feed(5);
      chk_result("t1", 12, 2, 0);
      handshake("t1");

      // bubble: -5, (2 idle), -2, -9 -> -2 @1
      begin_red(3);
      feed(-5);
      in_data = 16'sd100;
      tick();
      tick();
      chk("t2.bubble_valid", int'(out_valid), 0);
      chk("t2.bubble_ready", int'(in_ready),  1);
      feed(-2); feed(-9);
      chk_result("t2", -2, 1, 0);
      handshake("t2");

      // ties keep first index
      begin_red(4);
      feed(8); feed(1); feed(8); feed(8);
      chk_result("t3", 8, 0, 0);
      handshake("t3");

      begin_red(2);
      feed(-32768); feed(-32768);
      chk_result("t4", -32768, 0, 0);
      handshake("t4");

      // len=0 and held result
      begin_red(0);
      chk_result("t5", 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_result("t5.hold", 0, 0, 1);
         chk("t5.hold_busy", int'(busy), 1);
      end
      handshake("t5");

      // in_valid in IDLE is not consumed; len=1 boundary
      in_valid = 1'b1;
      in_data  = 16'sd50;
      tick();
      in_valid = 1'b0;
      chk("t6.idle_busy", int'(busy), 0);
      begin_red(1);
      feed(-3);
      chk_result("t6", -3, 0, 0);
      handshake("t6");

      // start during RUN ignored; start at handshake ignored
      begin_red(3);
      feed(2);
      start = 1'b1;
      len   = 16'd9;
      feed(9);
      start = 1'b0;
      feed(4);
      chk_result("t7", 9, 1, 0);
      start     = 1'b1;
      len       = 16'd5;
      out_ready = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      chk("t7.busy_after",  int'(busy),     0);
      chk("t7.ready_after", int'(in_ready), 0);
      tick();
      chk("t7.still_idle",  int'(busy),     0);

      // reset mid-vector, then fresh reduction with no stale max
      begin_red(5);
      feed(20); feed(30);
      g.reset = 1'b1;
      tick();
      g.reset = 1'b0;
      chk("t8.in_ready",  int'(in_ready),  0);
      chk("t8.out_valid", int'(out_valid), 0);
      chk("t8.busy",      int'(busy),      0);
      begin_red(2);
      feed(4); feed(6);
      chk_result("t8", 6, 1, 0);
      handshake("t8");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/smax_reduce_seq.md
Name: smax_reduce_seq

Overview:
- Sequencer that streams a vector of signed fixed-point elements through one shared `smax` instance and returns the running maximum and its index.
- Sits between a producer stream (e.g. a matrix row or column reader) and any consumer that needs max/argmax, such as softmax normalisation or max-pooling.
- Accepts one element per clock.
- Owns the `smax` feedback loop, element counting and result handshake.

Parameters:
- LEN_WIDTH, 16, width of the vector length and of the index output; the maximum vector length is 2^LEN_WIDTH-1.

Ports:
- `g`  interface  fixedp  carries `g.clk` and `g.reset` (listed below) plus `g.WIDTH`.
- `g.clk`  input  1  single clock; all state updates on its rising edge.
- `g.reset`  input  1  reset is synchronous and active-high.
- `start`  input  1  pulse: begin a reduction; sampled only in IDLE.
- `len`  input  LEN_WIDTH  number of elements; sampled with `start`.
- `in_data`  input  g.WIDTH  signed element.
- `in_valid`  input  1  element is present.
- `in_ready`  output  1  block accepts an element (1 only in RUN).
- `out_data`  output  g.WIDTH  signed maximum.
- `out_idx`  output  LEN_WIDTH  index of the first occurrence of the maximum.
- `out_empty`  output  1  the reduction had `len`=0.
- `out_valid`  output  1  result is present.
- `out_ready`  input  1  consumer takes the result.
- `busy`  output  1  state is not IDLE.

Behaviour:
- States: IDLE, RUN, DONE. Reset (synchronous, any state, including mid-vector) forces IDLE.
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `out_data`=0, `out_idx`=0, `out_empty`=0, element counter=0.
- Output gating: `out_data`, `out_idx` and `out_empty` are forced to 0 whenever `out_valid`=0. The `smax` register itself is not reset.
- IDLE:
  - `start`=1 and `len`!=0: latch `len`, clear the counter and running index, set the first flag, go to RUN.
  - `start`=1 and `len`=0: go to DONE with `out_empty`=1, `out_data`=0, `out_idx`=0.
- RUN:
  - `in_ready`=1. An accept is `in_valid` & `in_ready`.
  - smax input a = `in_data` on an accept; otherwise a = most-negative value (-2^(WIDTH-1)), so f holds its value over bubbles.
  - smax input b = most-negative value while the first flag is set; otherwise b = f (feedback).
  - Index register: on an accept, load the counter value if this is the first element or `in_data` > current f (strict). Ties keep the earlier index.
  - Counter increments on each accept.
  - On the accept with counter == `len`-1, go to DONE.
- DONE:
  - `out_valid`=1 starting the cycle after the last accept; latency is 1 clock.
  - a is forced to the most-negative value, so f is stable.
  - `out_valid` & `out_ready` returns the block to IDLE the next cycle.
  - Outputs hold while `out_ready`=0.
- `start` outside IDLE is ignored, including a `start` in the same cycle as the result handshake.
- `in_valid` outside RUN is ignored; no element is consumed.
- Arithmetic: comparisons are signed at full `g.WIDTH`. Max of all most-negative values returns the most-negative value with `out_idx`=0.

Decomposition:
- Shared fixed-point package holds:
  - the state enum (IDLE/RUN/DONE), reusable by other reduction sequencers;
  - a function returning the most-negative value for a given WIDTH.
- Exactly one sub-module: the existing `smax`, instantiated as the value datapath.
- Index tracking, counter and FSM stay in `smax_reduce_seq`.

Test Plan:
- WIDTH=16, `len`=4, elements 3,-7,12,5 with `in_valid` held high -> `out_valid` one cycle after the 4th accept; `out_data`=12, `out_idx`=2, `out_empty`=0.
- `len`=3, elements -5,-2,-9 with a 2-cycle `in_valid` bubble between elements 1 and 2 -> `out_data`=-2, `out_idx`=1; f unchanged across the bubble.
- `len`=4, elements 8,1,8,8 (tie) -> `out_data`=8, `out_idx`=0; `len`=2, elements -32768,-32768 -> `out_data`=-32768, `out_idx`=0.
- `len`=0 `start` -> DONE next cycle with `out_empty`=1, `out_data`=0, `out_idx`=0; `out_ready` low for 3 cycles holds the result, then release -> IDLE.
- `start` pulsed during RUN with `len`=9 -> ignored: the original `len`=3 reduction completes, result correct, `busy` drops after the handshake.
- `g.reset` asserted after 2 of 5 elements -> next cycle IDLE, `in_ready`=0, `out_valid`=0; a fresh `start` with `len`=2, elements 4,6 -> `out_data`=6, `out_idx`=1, with no stale maximum carried over.
